// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : calc_pkg
// Purpose  : Shared types and constants for the calculator datapath units
//            (inverse factorial FSM states, result record for the result mux).
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

  // Inverse-factorial sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } inv_fact_state_e;

  // Largest n with n! representable as a positive signed 32-bit value (12! < 2^31-1 < 13!)
  localparam int C_INV_FACT_MAX_N_W32 = 12;

  // Result width of n for a 32-bit operand: $clog2(32+1)
  localparam int C_INV_FACT_NW_W32 = 6;

  // Result record consumed by the calculator result mux
  typedef struct packed {
    logic [C_INV_FACT_NW_W32-1:0] n;
    logic                         exact;
    logic                         err;
  } inv_fact_res_t;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/inv_factorial_seq.sv
`default_nettype none
// ============================================================================
// Module   : inv_factorial_seq
// Purpose  : Iterative inverse factorial. For signed x returns the largest
//            n >= 1 with n! <= x and flags n! == x; x <= 0 reports err.
//            One multiply per clock, valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module inv_factorial_seq
  import calc_pkg::*;
#(
  parameter  int W  = 32,
  localparam int NW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] n,
  output logic          exact,
  output logic          err
);

  inv_fact_state_e r_state;
  inv_fact_state_e w_state_nxt;

  logic [W-1:0]   r_x;      // operand latched at accept
  logic [W-1:0]   r_acc;    // i!, always <= r_x so it fits in W bits
  logic [NW-1:0]  r_i;      // current factorial index
  logic [NW-1:0]  w_i_next;
  logic [2*W-1:0] w_trial;  // acc*(i+1) at full width: no wraparound
  logic           w_trial_fits;
  logic           w_x_nonpos;
  logic           w_accept;
  logic           w_deliver;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;

  // Signed x <= 0 from the raw bits of the presented operand
  assign w_x_nonpos = x[W-1] || (x == '0);

  assign w_i_next     = r_i + 1'b1;
  assign w_trial      = {{W{1'b0}}, r_acc} * {{(2*W-NW){1'b0}}, w_i_next};
  assign w_trial_fits = (w_trial <= {{W{1'b0}}, r_x});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: non-positive operands skip straight to DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_x_nonpos ? DONE : CALC;
        end
      end
      CALC: begin
        if (!w_trial_fits) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (w_deliver) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, one trial multiply per CALC cycle, result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_acc <= {{(W-1){1'b0}}, 1'b1};
      r_i   <= {{(NW-1){1'b0}}, 1'b1};
      n     <= '0;
      exact <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x   <= x;
            r_acc <= {{(W-1){1'b0}}, 1'b1};
            r_i   <= {{(NW-1){1'b0}}, 1'b1};
            if (w_x_nonpos) begin
              n     <= '0;
              exact <= 1'b0;
              err   <= 1'b1;
            end
          end
        end
        CALC: begin
          if (w_trial_fits) begin
            r_acc <= w_trial[W-1:0];
            r_i   <= w_i_next;
          end else begin
            n     <= r_i;
            exact <= (r_acc == r_x);
            err   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : inv_factorial_seq
`default_nettype wire

// File: tb/tb_inv_factorial_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_factorial_seq
// Purpose  : Self-checking bench for inv_factorial_seq: directed corner cases,
//            backpressure, mid-operation reset and randomized operands
//            against a plain-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_factorial_seq;

  localparam int W  = 32;
  localparam int NW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] n;
  logic          exact;
  logic          err;

  int n_vec  = 0;
  int n_miss = 0;

  inv_factorial_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n         (n),
    .exact     (exact),
    .err       (err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk factorials upward in 64-bit arithmetic
  function automatic void ref_model(input int signed xv, output int rn,
                                    output bit rex, output bit rerr);
    longint f;
    int     k;
    if (xv <= 0) begin
      rn = 0; rex = 1'b0; rerr = 1'b1;
    end else begin
      f = 1; k = 1;
      while (f * (k + 1) <= longint'(xv)) begin
        f = f * (k + 1);
        k = k + 1;
      end
      rn = k; rex = (f == longint'(xv)); rerr = 1'b0;
    end
  endfunction

  // One full transaction: accept, measure latency, hold backpressure, deliver
  task automatic run_op(input logic [W-1:0] xv, input int hold, input bit poke);
    int rn;
    bit rex;
    bit rerr;
    int lat;
    int exp_lat;
    int t;
    ref_model($signed(xv), rn, rex, rerr);
    // Error results appear on the accepting edge itself; others n edges later
    exp_lat = rerr ? 0 : rn;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready_before_accept", in_ready, 1);
    x = xv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (poke) x = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, exp_lat);
    check("out_valid", out_valid, 1);
    check("n", n, rn);
    check("exact", exact, rex);
    check("err", err, rerr);
    check("in_ready_busy", in_ready, 0);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      if (poke) x = $urandom;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_n", n, rn);
      check("hold_exact", exact, rex);
      check("hold_err", err, rerr);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_n_kept", n, rn);
    check("post_exact_kept", exact, rex);
  endtask

  initial begin
    logic [W-1:0] rx;
    int           seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_n_out", n, 0);
    check("rst_exact", exact, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corners
    run_op(32'd120, 0, 1'b0);
    run_op(32'd721, 1, 1'b0);
    run_op(32'd1, 0, 1'b0);
    run_op(32'd0, 0, 1'b0);
    run_op(-32'sd5, 2, 1'b0);
    run_op(32'h7FFF_FFFF, 10, 1'b1);
    run_op(32'd479001600, 10, 1'b1);
    run_op(32'd2, 0, 1'b0);

    // Asynchronous reset in the middle of a calculation
    x = 32'd5040;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_n", n, 0);
    check("midrst_exact", exact, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_output", seen, 0);
    run_op(32'd24, 1, 1'b0);

    // Randomized operands across magnitude classes
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: begin
          rx = 32'd1;
          for (int j = 2; j <= int'($urandom_range(2, 12)); j++) rx = rx * j;
        end
        1: begin
          rx = 32'd1;
          for (int j = 2; j <= int'($urandom_range(2, 12)); j++) rx = rx * j;
          rx = rx + 32'($urandom_range(0, 2)) - 32'd1;
        end
        2: rx = {1'b0, 31'($urandom)};
        default: rx = $urandom;
      endcase
      run_op(rx, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_inv_factorial_seq
`default_nettype wire
